video_timing_ctrl: RTL and testbench

Frame sequencer that generates the vsync/hsync/de timing consumed by the pixel-source file model and downstream image pipeline. It runs a programmed number of frames (or runs continuously until stopped) with parameterised porch/sync widths. It always finishes with a closing vsync pulse so the file model closes its frame cleanly. It sits at the head of the video simulation chain, driving the file model's `i_vsync`/`i_hsync`/`i_de`.

---
 rtl/video_timing_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_video_timing_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_ctrl.sv
// Video frame sequencer: produces vsync/hsync/de for a programmed number of
// frames (or continuously until stopped), then always closes with a vsync
// tail so the downstream file model can terminate its frame cleanly.
module video_timing_ctrl #(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned H_FP     = 8,
    parameter int unsigned H_SYNC   = 4,
    parameter int unsigned H_BP     = 8,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [7:0] i_frame_num,
    output logic       o_vsync,
    output logic       o_hsync,
    output logic       o_de,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_frame_cnt
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    typedef logic [HW-1:0] h_t;
    typedef logic [VW-1:0] v_t;

    localparam h_t H_LAST      = h_t'(H_TOTAL - 1);
    localparam h_t H_SYNC_END  = h_t'(H_SYNC);
    localparam h_t H_DE_BEG    = h_t'(H_SYNC + H_BP);
    localparam h_t H_DE_END    = h_t'(H_SYNC + H_BP + H_ACTIVE);
    localparam v_t V_LAST      = v_t'(V_TOTAL - 1);
    localparam v_t V_SYNC_END  = v_t'(V_SYNC);
    localparam v_t V_DE_BEG    = v_t'(V_SYNC + V_BP);
    localparam v_t V_DE_END    = v_t'(V_SYNC + V_BP + V_ACTIVE);
    localparam v_t V_TAIL_LAST = v_t'(V_SYNC - 1);

    // Every porch/sync/active width must be at least one.
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
        $error("video_timing_ctrl: all timing parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_TAIL
    } state_e;

    state_e     state_q, state_d;
    logic       launch_q, launch_d;
    h_t         h_q, h_d;
    v_t         v_q, v_d;
    logic [7:0] num_q, num_d;
    logic       stop_q, stop_d;
    logic [7:0] cnt_q, cnt_d;

    logic       vsync_d, hsync_d, de_d, busy_d, done_d;
    logic       vsync_q, hsync_q, de_q, busy_q, done_q;

    logic       line_end, frame_end, tail_end;
    logic [7:0] cnt_inc;

    assign line_end  = (h_q == H_LAST);
    assign frame_end = line_end && (v_q == V_LAST);
    assign tail_end  = line_end && (v_q == V_TAIL_LAST);
    assign cnt_inc   = cnt_q + 8'd1;

    // State register and timing counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            launch_q <= 1'b0;
            h_q      <= '0;
            v_q      <= '0;
            num_q    <= '0;
            stop_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            launch_q <= launch_d;
            h_q      <= h_d;
            v_q      <= v_d;
            num_q    <= num_d;
            stop_q   <= stop_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state and counter sequencing.
    // An accepted start spends one launch cycle in IDLE so that counter
    // position (0,0) lines up with the registered outputs one cycle later;
    // this keeps the counters and the visible outputs on the same timeline.
    always_comb begin
        state_d  = state_q;
        launch_d = 1'b0;
        h_d      = h_q;
        v_d      = v_q;
        num_d    = num_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch_q) begin
                    state_d = S_ACTIVE;
                    h_d     = '0;
                    v_d     = '0;
                end else if (i_start) begin
                    launch_d = 1'b1;
                    cnt_d    = '0;
                    num_d    = i_frame_num;
                    stop_d   = 1'b0;
                end
            end
            S_ACTIVE: begin
                stop_d = stop_q | i_stop;
                h_d    = line_end ? '0 : h_q + h_t'(1);
                if (line_end) begin
                    v_d = v_q + v_t'(1);
                end
                if (frame_end) begin
                    cnt_d = cnt_inc;
                    v_d   = '0;
                    if (((num_q != '0) && (cnt_inc == num_q)) || stop_q || i_stop) begin
                        state_d = S_TAIL;
                    end
                end
            end
            S_TAIL: begin
                h_d = line_end ? '0 : h_q + h_t'(1);
                if (line_end) begin
                    v_d = v_q + v_t'(1);
                end
                if (tail_end) begin
                    state_d = S_IDLE;
                    h_d     = '0;
                    v_d     = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming counter position.
    always_comb begin
        vsync_d = 1'b0;
        hsync_d = 1'b0;
        de_d    = 1'b0;
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_q == S_TAIL) && (state_d == S_IDLE);
        if (state_d == S_ACTIVE) begin
            vsync_d = (v_d < V_SYNC_END);
            hsync_d = (h_d < H_SYNC_END);
            de_d    = (h_d >= H_DE_BEG) && (h_d < H_DE_END) &&
                      (v_d >= V_DE_BEG) && (v_d < V_DE_END);
        end else if (state_d == S_TAIL) begin
            vsync_d = 1'b1;
            hsync_d = (h_d < H_SYNC_END);
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            de_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            vsync_q <= vsync_d;
            hsync_q <= hsync_d;
            de_q    <= de_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_vsync     = vsync_q;
    assign o_hsync     = hsync_q;
    assign o_de        = de_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_frame_cnt = cnt_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl: reference model driven by a linear cycle
// index plus directed runs with hand-computed event positions.
module tb_video_timing_ctrl;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FR = HT * VT;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_stop = 1'b0;
    logic [7:0] i_frame_num = '0;
    logic       o_vsync, o_hsync, o_de, o_busy, o_done;
    logic [7:0] o_frame_cnt;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_stop(i_stop),
        .i_frame_num(i_frame_num), .o_vsync(o_vsync), .o_hsync(o_hsync),
        .o_de(o_de), .o_busy(o_busy), .o_done(o_done), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 launch, 2 frames, 3 tail.
    // m_t is the cycle index within the run (frames) or within the tail.
    int m_phase = 0, m_t = 0, m_cnt = 0, m_num = 0;
    bit m_stop = 0, m_done = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_t = 0; m_cnt = 0; m_num = 0; m_stop = 0; m_done = 0;
        end else begin
            m_done = 0;
            case (m_phase)
                0: if (i_start) begin
                    m_phase = 1; m_num = i_frame_num; m_stop = 0; m_cnt = 0;
                end
                1: begin m_phase = 2; m_t = 0; end
                2: begin
                    if ((m_t % FR) == FR - 1) begin
                        m_cnt = (m_cnt + 1) % 256;
                        if ((m_num != 0 && m_cnt == m_num) || m_stop || i_stop) begin
                            m_phase = 3; m_t = 0;
                        end else m_t++;
                    end else m_t++;
                    if (i_stop) m_stop = 1;
                end
                default: begin
                    if (m_t == VS * HT - 1) begin m_phase = 0; m_done = 1; end
                    else m_t++;
                end
            endcase
        end
    end

    int p, h, v;
    bit evs, ehs, ede, eb;

    always @(negedge clk) begin
        evs = 0; ehs = 0; ede = 0; eb = 0;
        if (m_phase == 2) begin
            p = m_t % FR; h = p % HT; v = p / HT;
            evs = (v < VS);
            ehs = (h < HS);
            ede = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            eb  = 1;
        end else if (m_phase == 3) begin
            evs = 1;
            ehs = ((m_t % HT) < HS);
            eb  = 1;
        end
        chk("vsync", int'(o_vsync), int'(evs));
        chk("hsync", int'(o_hsync), int'(ehs));
        chk("de", int'(o_de), int'(ede));
        chk("busy", int'(o_busy), int'(eb));
        chk("done", int'(o_done), int'(m_done));
        chk("frame_cnt", int'(o_frame_cnt), m_cnt);
    end

    bit vs_at [0:299];

    // Caller is at a negedge; start is sampled by the next rising edge (N).
    task automatic start_run(input logic [7:0] fn, input logic stp);
        i_start = 1'b1; i_frame_num = fn; i_stop = stp;
        @(negedge clk);
        i_start = 1'b0; i_stop = 1'b0;
    endtask

    // Observe cycles N+1..N+limit; optionally drive start/stop in cycle k.
    task automatic watch(input int limit, input int sk1, input int sk2, input int stk,
                         output int first_de, output int n_de, output int runs, output int done_k);
        bit prev_de;
        prev_de = 0; first_de = -1; n_de = 0; runs = 0; done_k = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            vs_at[k] = o_vsync;
            if (o_de) begin
                if (first_de < 0) first_de = k;
                n_de++;
                if (!prev_de) runs++;
            end
            prev_de = o_de;
            i_start = (k == sk1) || (k == sk2);
            i_stop  = (k == stk);
            if (o_done) begin
                done_k = k;
                break;
            end
        end
        i_start = 1'b0; i_stop = 1'b0;
    endtask

    int fd, nd, rn, dk;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_vsync", int'(o_vsync), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_cnt", int'(o_frame_cnt), 0);
        rst_n = 1'b1;

        // stop while idle does nothing
        @(negedge clk); i_stop = 1'b1;
        @(negedge clk); i_stop = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_stop_busy", int'(o_busy), 0);

        // single frame
        start_run(8'd1, 1'b0);
        watch(70, -1, -1, -1, fd, nd, rn, dk);
        chk("f1_first_de", fd, 17);
        chk("f1_n_de", nd, 12);
        chk("f1_de_runs", rn, 3);
        chk("f1_done_at", dk, 50);
        chk("f1_cnt", int'(o_frame_cnt), 1);
        chk("f1_vs1", int'(vs_at[1]), 1);
        chk("f1_vs7", int'(vs_at[7]), 1);
        chk("f1_vs8", int'(vs_at[8]), 0);
        chk("f1_vs42", int'(vs_at[42]), 0);
        chk("f1_vs43", int'(vs_at[43]), 1);
        chk("f1_vs49", int'(vs_at[49]), 1);

        // two frames, started in the done cycle; starts in ACTIVE and TAIL ignored
        start_run(8'd2, 1'b0);
        watch(110, 30, 88, -1, fd, nd, rn, dk);
        chk("f2_first_de", fd, 17);
        chk("f2_n_de", nd, 24);
        chk("f2_de_runs", rn, 6);
        chk("f2_done_at", dk, 92);
        chk("f2_cnt", int'(o_frame_cnt), 2);
        chk("f2_vs43", int'(vs_at[43]), 1);

        // start and stop together in idle: normal run
        repeat (3) @(negedge clk);
        start_run(8'd1, 1'b1);
        watch(70, -1, -1, -1, fd, nd, rn, dk);
        chk("ss_n_de", nd, 12);
        chk("ss_done_at", dk, 50);
        chk("ss_cnt", int'(o_frame_cnt), 1);

        // continuous, stop in the middle of frame 3
        repeat (2) @(negedge clk);
        start_run(8'd0, 1'b0);
        watch(200, -1, -1, 100, fd, nd, rn, dk);
        chk("cm_n_de", nd, 36);
        chk("cm_done_at", dk, 134);
        chk("cm_cnt", int'(o_frame_cnt), 3);

        // continuous, stop on the last cycle of frame 3
        repeat (2) @(negedge clk);
        start_run(8'd0, 1'b0);
        watch(200, -1, -1, 126, fd, nd, rn, dk);
        chk("cl_n_de", nd, 36);
        chk("cl_done_at", dk, 134);
        chk("cl_cnt", int'(o_frame_cnt), 3);

        // reset in the active area of frame 1
        repeat (2) @(negedge clk);
        start_run(8'd1, 1'b0);
        repeat (19) @(negedge clk);
        chk("mr_de_before", int'(o_de), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("mr_de", int'(o_de), 0);
        chk("mr_hsync", int'(o_hsync), 0);
        chk("mr_busy", int'(o_busy), 0);
        @(negedge clk);
        chk("mr_done", int'(o_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_run(8'd1, 1'b0);
        watch(70, -1, -1, -1, fd, nd, rn, dk);
        chk("ar_first_de", fd, 17);
        chk("ar_n_de", nd, 12);
        chk("ar_done_at", dk, 50);
        chk("ar_cnt", int'(o_frame_cnt), 1);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL global_timeout: got %0t, want completion", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "bench time limit expired");
    end

endmodule
